// File: rtl/multiplicacion_secuencial.sv
// ---------------------------------------------------------------------------
// multiplicacion_secuencial
//
// Sequential shift-add multiplier with a start/done handshake, registered
// outputs and a runtime signed/unsigned mode. It is the sequential successor
// of the combinational M-bit multiplier in the lab arithmetic set.
//
// The operation works on magnitudes. The sign of the product is applied once,
// in the FIX state, after all partial products have been accumulated.
//
// Handshake:
//   'start' is sampled only in IDLE. On that edge the operands and the mode are
//   captured, so later changes on the inputs do not affect the operation.
//   'busy' is high while state is CALC or FIX. 'done' is a one-cycle pulse in
//   the cycle where 'result' and 'CarryOut' carry a new value. 'start' may be
//   asserted in the same cycle that 'done' is high, because the FSM is already
//   back in IDLE then.
//
// Parameters:
//   M            operand width in bits (M >= 2); the result is 2*M bits wide
//
// Ports:
//   clk          system clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   start        operation request; sampled only while idle
//   signed_mode  0 = unsigned operands, 1 = two's-complement operands
//   input1       multiplicand (M bits)
//   input2       multiplier (M bits)
//   result       product (2*M bits), held until the next completion
//   CarryOut     the product does not fit in M bits in the selected mode
//   busy         an operation is in progress (CALC or FIX)
//   done         one-cycle pulse when result/CarryOut update
//   state_dbg    current FSM state (0 IDLE, 1 CALC, 2 FIX), for observation
//
// Optional build macro:
//   MULT_EARLY_EXIT_EN  when defined, CALC also moves on to FIX as soon as the
//                       remaining multiplier bits are all zero. The product
//                       and CarryOut are unchanged; only the latency is
//                       shorter.
// ---------------------------------------------------------------------------
module multiplicacion_secuencial #(
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [M-1:0]   input1,
    input  logic [M-1:0]   input2,
    output logic [2*M-1:0] result,
    output logic           CarryOut,
    output logic           busy,
    output logic           done,
    output logic [1:0]     state_dbg
);

    localparam int CW = (M > 2) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [M-1:0]   mag1;
    logic [M-1:0]   mag2;
    logic           neg;
    logic           smode;
    logic [2*M-1:0] acc;
    logic [CW-1:0]  count;

    logic           last_iter;
    logic [2*M-1:0] addend;
    logic [2*M-1:0] acc_next;
    logic [2*M-1:0] prod;
    logic           overflow;

    // Absolute value as an M-bit unsigned number. The most negative signed
    // value wraps onto itself, which is exactly its magnitude 2^(M-1).
    function automatic logic [M-1:0] magnitude(input logic [M-1:0] v, input logic s);
        return (s && v[M-1]) ? (~v + M'(1)) : v;
    endfunction

`ifdef MULT_EARLY_EXIT_EN
    // Stop once the shifted multiplier is about to become zero. No later
    // iteration could add anything to the accumulator.
    assign last_iter = (count == CW'(M - 1)) || ((mag2 >> 1) == '0);
`else
    assign last_iter = (count == CW'(M - 1));
`endif

    // Partial product of this iteration: the multiplicand aligned to the
    // weight of the multiplier bit that is being consumed.
    assign addend   = {{M{1'b0}}, mag1} << count;
    assign acc_next = mag2[0] ? (acc + addend) : acc;

    // Sign restore and overflow check. Both are used only in FIX.
    assign prod = neg ? (~acc + (2*M)'(1)) : acc;

    always_comb begin
        overflow = 1'b0;
        if (smode) begin
            // A signed M-bit value needs the top M+1 bits to be a sign run.
            overflow = !((&prod[2*M-1:M-1]) || (~|prod[2*M-1:M-1]));
        end else begin
            overflow = |prod[2*M-1:M];
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (state != IDLE);
        state_dbg = state;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mag1     <= '0;
            mag2     <= '0;
            neg      <= 1'b0;
            smode    <= 1'b0;
            acc      <= '0;
            count    <= '0;
            result   <= '0;
            CarryOut <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag1  <= magnitude(input1, signed_mode);
                        mag2  <= magnitude(input2, signed_mode);
                        neg   <= signed_mode & (input1[M-1] ^ input2[M-1]);
                        smode <= signed_mode;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mag2  <= mag2 >> 1;
                    count <= count + CW'(1);
                end
                FIX: begin
                    result   <= prod;
                    CarryOut <= overflow;
                    done     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicacion_secuencial.sv
// ---------------------------------------------------------------------------
// Testbench for multiplicacion_secuencial (M = 4).
//
// The expected product and overflow come from integer arithmetic on the
// operands as numbers. The expected latency is derived from the operand
// value. Expectations are queued when an operation is launched and popped
// when 'done' is seen.
// ---------------------------------------------------------------------------
module tb_multiplicacion_secuencial;

    localparam int M        = 4;
    localparam int TIMEOUT  = 50;

    logic           clk;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [M-1:0]   input1;
    logic [M-1:0]   input2;
    logic [2*M-1:0] result;
    logic           CarryOut;
    logic           busy;
    logic           done;
    logic [1:0]     state_dbg;

    int checks = 0;
    int errors = 0;

    // Each entry is {CarryOut, result}.
    logic [2*M:0] exp_q[$];

    multiplicacion_secuencial #(.M(M)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .input1      (input1),
        .input2      (input2),
        .result      (result),
        .CarryOut    (CarryOut),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int as_number(input logic [M-1:0] v, input logic s);
        int n;
        n = int'(v);
        if (s && v[M-1]) n = n - (1 << M);
        return n;
    endfunction

    function automatic logic [2*M:0] model(input logic [M-1:0] a, input logic [M-1:0] b,
                                           input logic s);
        int p;
        logic c;
        logic [2*M-1:0] r;
        p = as_number(a, s) * as_number(b, s);
        if (s) c = (p < -(1 << (M - 1))) || (p > (1 << (M - 1)) - 1);
        else   c = (p > (1 << M) - 1);
        r = p[2*M-1:0];
        return {c, r};
    endfunction

    function automatic int exp_latency(input logic [M-1:0] b, input logic s);
`ifdef MULT_EARLY_EXIT_EN
        int mag;
        int h;
        mag = as_number(b, s);
        if (mag < 0) mag = -mag;
        if (mag == 0) return 2;
        h = 0;
        for (int i = 0; i < 2 * M; i++) if ((mag >> i) & 1) h = i;
        return h + 2;
`else
        return M + 1;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Launches an operation and returns just after the start edge.
    task automatic start_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic s);
        @(negedge clk);
        input1      = a;
        input2      = b;
        signed_mode = s;
        start       = 1'b1;
        exp_q.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        start       = 1'b0;
        input1      = M'($urandom);
        input2      = M'($urandom);
        signed_mode = 1'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, required 1", busy);
        end
    endtask

    // Waits for done; 'elapsed' is the number of edges already past the start
    // edge. Checks latency, busy in the done cycle, result and CarryOut.
    task automatic finish_op(input int elapsed, input int lat_req, input string name);
        int lat;
        logic [2*M:0] e;
        lat = elapsed;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got no done in %0d edges, required done", name, lat);
            return;
        end
        checks++;
        if (lat !== lat_req) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, lat_req);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_in_done: got %b, required 0", name, busy);
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got done, required no pending operation", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (result !== e[2*M-1:0]) begin
            errors++;
            $display("FAIL %s_result: got %h, required %h", name, result, e[2*M-1:0]);
        end
        checks++;
        if (CarryOut !== e[2*M]) begin
            errors++;
            $display("FAIL %s_carry: got %b, required %b", name, CarryOut, e[2*M]);
        end
    endtask

    task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic s,
                          input string name);
        start_op(a, b, s);
        finish_op(0, exp_latency(b, s), name);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        input1 = '0;
        input2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({result, CarryOut, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got result=%h carry=%b busy=%b done=%b, required all 0",
                     result, CarryOut, busy, done);
        end
    endtask

    task automatic test_directed();
        run_op(4'd2, 4'd3, 1'b0, "u_2x3");
        run_op(4'd15, 4'd15, 1'b0, "u_15x15");
        run_op(4'd0, 4'd4, 1'b0, "u_0x4");
        run_op(4'hD, 4'd5, 1'b1, "s_m3x5");
        run_op(4'hE, 4'd3, 1'b1, "s_m2x3");
        run_op(4'h8, 4'h8, 1'b1, "s_m8xm8");
        run_op(4'd3, 4'hE, 1'b1, "s_3xm2");
        run_op(4'h0, 4'hB, 1'b1, "s_0xm5");
        run_op(4'd7, 4'd1, 1'b0, "u_7x1");
        run_op(4'd7, 4'd0, 1'b0, "u_7x0");
        run_op(4'd3, 4'd8, 1'b0, "u_3x8");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(M'($urandom), M'($urandom_range(0, (1 << M) - 1)), 1'($urandom), "random");
        end
    endtask

    task automatic test_ignore_start();
        start_op(4'd2, 4'd3, 1'b0);
        @(posedge clk);
        #1;
        // Pulse start with new operands during the operation.
        input1      = 4'd7;
        input2      = 4'd7;
        signed_mode = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_op(2, exp_latency(4'd3, 1'b0), "ignore_start");
    endtask

    task automatic test_back_to_back();
        run_op(4'd2, 4'd3, 1'b0, "b2b_first");
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_cycle: got done=%b, required 1", done);
        end
        // start_op waits for the next negedge, so re-align: launch directly.
        input1      = 4'd5;
        input2      = 4'd5;
        signed_mode = 1'b0;
        start       = 1'b1;
        exp_q.push_back(model(4'd5, 4'd5, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b, required 1", busy);
        end
        finish_op(0, exp_latency(4'd5, 1'b0), "b2b_second");
    endtask

    task automatic test_reset_midop();
        int pulses;
        start_op(4'd15, 4'd15, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if ({result, CarryOut, busy, done} !== '0) begin
            errors++;
            $display("FAIL midop_reset: got result=%h carry=%b busy=%b done=%b, required all 0",
                     result, CarryOut, busy, done);
        end
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midop_no_done: got %0d done pulses, required 0", pulses);
        end
        run_op(4'd2, 4'd2, 1'b0, "after_reset_2x2");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
